// File: rtl/eccdh_host_sequencer.sv
// eccdh_host_sequencer: host-side start/done sequencer for the ECCDH3DES controller (ECC pass 1, ECC pass 2, DES session).
module eccdh_host_sequencer #(
  parameter int              TO_W         = 24,
  parameter logic [TO_W-1:0] ECC_TIMEOUT  = 24'd1_000_000,
  parameter int              INIT_CYCLES  = 50,
  parameter int              BLOCK_CYCLES = 2,
  parameter int              DRAIN_CYCLES = 50
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         go,
  input  logic         run_ecc1,
  input  logic         run_ecc2,
  input  logic         run_des,
  input  logic [15:0]  num_blocks,
  input  logic         ecc1_done,
  input  logic         ecc2_done,
  input  logic [163:0] PuX,
  input  logic [163:0] PuY,
  output logic         ecc_start1,
  output logic         ecc_start2,
  output logic         des_start,
  output logic [163:0] pub_x,
  output logic [163:0] pub_y,
  output logic         blk_strobe,
  output logic         busy,
  output logic         done,
  output logic         err_timeout
);
  typedef enum logic [3:0] {
    IDLE, E1_REQ, E1_WAIT, E2_REQ, E2_WAIT, D_INIT, D_DATA, D_DRAIN, FINISH, ERROR
  } state_t;
  state_t state, nxt, after_e1, after_e2;
  logic [TO_W-1:0] cnt;
  logic [15:0]     blk, nb;
  logic            run2, rund, blk_end;
  assign blk_end = cnt == TO_W'(BLOCK_CYCLES - 1);
  always_comb begin
    after_e2 = rund ? D_INIT : FINISH;
    after_e1 = run2 ? E2_REQ : after_e2;
    nxt = state;
    case (state)
      IDLE:    nxt = !go ? IDLE : run_ecc1 ? E1_REQ : run_ecc2 ? E2_REQ : run_des ? D_INIT : FINISH;
      E1_REQ:  nxt = E1_WAIT;
      E1_WAIT: nxt = ecc1_done ? after_e1 : cnt == ECC_TIMEOUT - 1'b1 ? ERROR : E1_WAIT;
      E2_REQ:  nxt = E2_WAIT;
      E2_WAIT: nxt = ecc2_done ? after_e2 : cnt == ECC_TIMEOUT - 1'b1 ? ERROR : E2_WAIT;
      D_INIT:  nxt = cnt != TO_W'(INIT_CYCLES - 1) ? D_INIT : nb == 16'd0 ? D_DRAIN : D_DATA;
      D_DATA:  nxt = (blk_end && blk == nb - 16'd1) ? D_DRAIN : D_DATA;
      D_DRAIN: nxt = cnt == TO_W'(DRAIN_CYCLES - 1) ? FINISH : D_DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      blk         <= '0;
      nb          <= '0;
      run2        <= 1'b0;
      rund        <= 1'b0;
      pub_x       <= '0;
      pub_y       <= '0;
      ecc_start1  <= 1'b0;
      ecc_start2  <= 1'b0;
      des_start   <= 1'b0;
      blk_strobe  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state || (state == D_DATA && blk_end)) ? '0 : cnt + 1'b1;
      blk   <= state != D_DATA ? '0 : blk_end ? blk + 16'd1 : blk;
      if (state == IDLE && go) begin
        run2 <= run_ecc2;
        rund <= run_des;
        nb   <= num_blocks;
      end
      if (state == E1_WAIT && ecc1_done) begin
        pub_x <= PuX;
        pub_y <= PuY;
      end
      ecc_start1  <= nxt == E1_REQ;
      ecc_start2  <= nxt == E2_REQ;
      des_start   <= nxt == D_INIT || nxt == D_DATA;
      blk_strobe  <= nxt == D_DATA && (state != D_DATA || blk_end);
      busy        <= nxt != IDLE;
      done        <= nxt == FINISH;
      err_timeout <= (state == IDLE && go) ? 1'b0 : err_timeout | (nxt == ERROR);
    end
  end
endmodule

// File: tb/tb_eccdh_host_sequencer.sv
// tb_eccdh_host_sequencer: directed checks of phase ordering, DES timing, timeout and async reset.
module tb_eccdh_host_sequencer;
  logic clk = 1'b0, n_rst = 1'b0, go = 1'b0;
  logic run_ecc1 = 1'b0, run_ecc2 = 1'b0, run_des = 1'b0;
  logic [15:0] num_blocks = '0;
  logic ecc1_done = 1'b0, ecc2_done = 1'b0;
  logic [163:0] PuX = '0, PuY = '0, pub_x, pub_y;
  logic ecc_start1, ecc_start2, des_start, blk_strobe, busy, done, err_timeout;
  int tests = 0, fails = 0;
  int s1, s2, n1, n2, df, dn, fall, ns, dt, nd, et, pt, end_t;
  logic [63:0] mask, exp_mask;

  eccdh_host_sequencer #(.ECC_TIMEOUT(24'd16)) dut (
    .clk(clk), .n_rst(n_rst), .go(go), .run_ecc1(run_ecc1), .run_ecc2(run_ecc2),
    .run_des(run_des), .num_blocks(num_blocks), .ecc1_done(ecc1_done), .ecc2_done(ecc2_done),
    .PuX(PuX), .PuY(PuY), .ecc_start1(ecc_start1), .ecc_start2(ecc_start2),
    .des_start(des_start), .pub_x(pub_x), .pub_y(pub_y), .blk_strobe(blk_strobe),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [163:0] obs, input logic [163:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues go, then plays the controller: answers each start after dly cycles (never if dly<0)
  task automatic run(input bit e1, input bit e2, input bit d, input logic [15:0] nbk,
                     input int dly, input bit dis, input logic [163:0] px, input logic [163:0] py);
    bit ended = 1'b0;
    s1 = -1; s2 = -1; n1 = 0; n2 = 0; df = -1; dn = 0; fall = -1; ns = 0;
    dt = -1; nd = 0; et = -1; pt = -1; end_t = -1; mask = '0;
    run_ecc1 = e1; run_ecc2 = e2; run_des = d; num_blocks = nbk; go = 1'b1;
    step();
    go = 1'b0; run_ecc1 = 1'b0; run_ecc2 = 1'b0; run_des = 1'b0; num_blocks = '0;
    for (int t = 1; t <= 400; t++) begin
      if (!busy) begin end_t = t; ended = 1'b1; break; end
      if (ecc_start1) begin n1++; if (s1 < 0) s1 = t; end
      if (ecc_start2) begin n2++; if (s2 < 0) s2 = t; end
      if (des_start) begin
        dn++;
        if (df < 0) df = t;
        if (blk_strobe && dn < 64) mask[dn] = 1'b1;
      end else if (df >= 0 && fall < 0) fall = t;
      if (blk_strobe) ns++;
      if (err_timeout && et < 0) et = t;
      if (pub_x === px && pub_y === py && pt < 0) pt = t;
      if (done) begin nd++; dt = t; end
      ecc1_done = dly >= 0 && s1 > 0 && t == s1 + dly;
      PuX = ecc1_done ? px : '1;
      PuY = ecc1_done ? py : '1;
      ecc2_done = (dly >= 0 && s2 > 0 && t == s2 + dly) || (dis && s1 > 0 && s2 < 0 && t == s1 + 3);
      go = dis && des_start && dn == 52;
      run_des = go;
      num_blocks = go ? 16'd9 : 16'd0;
      step();
    end
    go = 1'b0; run_des = 1'b0; ecc1_done = 1'b0; ecc2_done = 1'b0; num_blocks = '0;
    if (!ended) chk("seq_bound", 1, 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_s1"}, s1, 1);
    chk({tag, "_n1"}, n1, 1);
    chk({tag, "_s2"}, s2, 7);
    chk({tag, "_n2"}, n2, 1);
    chk({tag, "_des_first"}, df, 13);
    chk({tag, "_des_len"}, dn, 56);
    chk({tag, "_strobe_mask"}, mask, exp_mask);
    chk({tag, "_strobe_cnt"}, ns, 3);
    chk({tag, "_drain"}, dt - fall, 50);
    chk({tag, "_done_cnt"}, nd, 1);
    chk({tag, "_end"}, end_t, 120);
    chk({tag, "_pub"}, pt, 7);
  endtask

  initial begin
    exp_mask = '0;
    exp_mask[51] = 1'b1; exp_mask[53] = 1'b1; exp_mask[55] = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_des", des_start, 0);
    chk("rst_start", {ecc_start1, ecc_start2, blk_strobe, done, err_timeout}, 0);
    chk("rst_pub", pub_x | pub_y, 0);
    n_rst = 1'b1;
    step();
    run(1, 0, 0, 16'd0, 10, 0, 164'h1234, 164'h5678);
    chk("e1_s1", s1, 1);
    chk("e1_n1", n1, 1);
    chk("e1_n2", n2, 0);
    chk("e1_pub_t", pt, 12);
    chk("e1_done_t", dt, 12);
    chk("e1_done_cnt", nd, 1);
    chk("e1_busy_fall", end_t, 13);
    chk("e1_pub_x", pub_x, 164'h1234);
    chk("e1_pub_y", pub_y, 164'h5678);
    run(1, 1, 1, 16'd3, 5, 0, {4'hA, 156'h0, 4'h5}, {4'h3, 156'h0, 4'hC});
    check_all("all");
    chk("all_pub_x", pub_x, {4'hA, 156'h0, 4'h5});
    run(1, 1, 1, 16'd3, 5, 1, 164'h77, 164'h88);
    check_all("dis");
    run(0, 0, 1, 16'd0, 5, 0, '0, '0);
    chk("d0_first", df, 1);
    chk("d0_len", dn, 50);
    chk("d0_strobe", ns, 0);
    chk("d0_drain", dt - fall, 50);
    chk("d0_end", end_t, 102);
    run(1, 0, 0, 16'd0, -1, 0, '0, '0);
    chk("to_s1", s1, 1);
    chk("to_err_t", et, 18);
    chk("to_done_cnt", nd, 0);
    chk("to_end", end_t, 19);
    chk("to_sticky", err_timeout, 1);
    step();
    chk("to_sticky2", err_timeout, 1);
    run(0, 0, 0, 16'd0, 5, 0, '0, '0);
    chk("none_done_t", dt, 1);
    chk("none_err_cleared", et, -1);
    chk("none_end", end_t, 2);
    run_des = 1'b1; num_blocks = 16'd5; go = 1'b1;
    step();
    go = 1'b0; run_des = 1'b0; num_blocks = '0;
    for (int i = 0; i < 100 && !blk_strobe; i++) step();
    chk("rst_mid_strobe_seen", blk_strobe, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_mid_des", des_start, 0);
    chk("rst_mid_strobe", blk_strobe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pub", pub_x, 0);
    step();
    n_rst = 1'b1;
    step();
    run(0, 0, 1, 16'd1, 5, 0, '0, '0);
    chk("post_len", dn, 52);
    chk("post_strobe", ns, 1);
    chk("post_done", nd, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
